// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the VGA timing generator and the pixel pipeline.
// The generator drives every signal (master); downstream stages only observe (slave).
interface vga_timing_gen_if;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       blank;
    logic       hs;
    logic       vs;
    logic       line_start;
    logic       frame_start;
    logic [7:0] frame_count;

    modport master (
        output DrawX, DrawY, blank, hs, vs, line_start, frame_start, frame_count
    );

    modport slave (
        input  DrawX, DrawY, blank, hs, vs, line_start, frame_start, frame_count
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator (640x480@60 Hz by default on a 25 MHz pixel clock).
// Horizontal/vertical counters feed the pixel pipeline directly; hs/vs pass through
// a short shift register so they line up with the pipeline's colour output.
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int SYNC_DELAY = 1
) (
    input  logic             vga_clk,
    input  logic             reset_n,
    vga_timing_gen_if.master vga
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // All counter compares are done at 10 bits.
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    // Timing totals must fit the 10-bit counters; the delay line is at most 4 deep.
    if ((H_TOTAL > 1024) || (V_TOTAL > 1024)) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 1024");
    end
    if ((SYNC_DELAY < 0) || (SYNC_DELAY > 4)) begin : g_bad_delay
        $error("vga_timing_gen: SYNC_DELAY must be 0..4");
    end

    logic [9:0] hc_q, hc_d;
    logic [9:0] vc_q, vc_d;
    logic [7:0] frame_count_q, frame_count_d;
    logic       line_end_s;
    logic       frame_end_s;
    logic       hs_raw_s;
    logic       vs_raw_s;

    // Next-state for the raster counters and the frame counter.
    always_comb begin
        hc_d          = hc_q;
        vc_d          = vc_q;
        frame_count_d = frame_count_q;
        line_end_s    = (hc_q == H_LAST);
        frame_end_s   = line_end_s && (vc_q == V_LAST);

        if (line_end_s) begin
            hc_d = 10'd0;
        end else begin
            hc_d = hc_q + 10'd1;
        end

        if (frame_end_s) begin
            vc_d          = 10'd0;
            frame_count_d = frame_count_q + 8'd1;
        end else if (line_end_s) begin
            vc_d = vc_q + 10'd1;
        end else begin
            vc_d = vc_q;
        end
    end

    // Counter registers; reset restarts the raster at (0,0).
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            hc_q          <= 10'd0;
            vc_q          <= 10'd0;
            frame_count_q <= 8'd0;
        end else begin
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            frame_count_q <= frame_count_d;
        end
    end

    // Undelayed sync decode (active-low inside the sync windows).
    always_comb begin
        hs_raw_s = 1'b1;
        vs_raw_s = 1'b1;
        if ((hc_q >= HS_BEG) && (hc_q < HS_END)) begin
            hs_raw_s = 1'b0;
        end else begin
            hs_raw_s = 1'b1;
        end
        if ((vc_q >= VS_BEG) && (vc_q < VS_END)) begin
            vs_raw_s = 1'b0;
        end else begin
            vs_raw_s = 1'b1;
        end
    end

    assign vga.DrawX       = hc_q;
    assign vga.DrawY       = vc_q;
    assign vga.blank       = (hc_q < H_ACT) && (vc_q < V_ACT) && reset_n;
    assign vga.line_start  = (hc_q == 10'd0);
    assign vga.frame_start = (hc_q == 10'd0) && (vc_q == 10'd0);
    assign vga.frame_count = frame_count_q;

    if (SYNC_DELAY == 0) begin : g_no_delay
        assign vga.hs = hs_raw_s;
        assign vga.vs = vs_raw_s;
    end else begin : g_delay
        logic [SYNC_DELAY-1:0] hs_dly_q, hs_dly_d;
        logic [SYNC_DELAY-1:0] vs_dly_q, vs_dly_d;

        // Shift the raw syncs in at bit 0; the oldest stage drives the connector.
        always_comb begin
            hs_dly_d = SYNC_DELAY'({hs_dly_q, hs_raw_s});
            vs_dly_d = SYNC_DELAY'({vs_dly_q, vs_raw_s});
        end

        // Delay stages clear to deasserted so no partial pulse survives a reset.
        always_ff @(posedge vga_clk or negedge reset_n) begin
            if (!reset_n) begin
                hs_dly_q <= '1;
                vs_dly_q <= '1;
            end else begin
                hs_dly_q <= hs_dly_d;
                vs_dly_q <= vs_dly_d;
            end
        end

        assign vga.hs = hs_dly_q[SYNC_DELAY-1];
        assign vga.vs = vs_dly_q[SYNC_DELAY-1];
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three full-size instances (SYNC_DELAY 1, 0, 3) and one
// shrunken-timing instance so whole frames and the frame counter wrap fit in a short run.
// Stimulus pushes per-cycle expectations into a queue; a negedge monitor pops and compares.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    vga_timing_gen_if if0 ();
    vga_timing_gen_if if1 ();
    vga_timing_gen_if if2 ();
    vga_timing_gen_if if3 ();

    vga_timing_gen #(.SYNC_DELAY(1)) u_d1 (.vga_clk(clk), .reset_n(rst_n), .vga(if0));
    vga_timing_gen #(.SYNC_DELAY(0)) u_d0 (.vga_clk(clk), .reset_n(rst_n), .vga(if1));
    vga_timing_gen #(.SYNC_DELAY(3)) u_d3 (.vga_clk(clk), .reset_n(rst_n), .vga(if2));
    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_DELAY(1)
    ) u_sm (.vga_clk(clk), .reset_n(rst_n), .vga(if3));

    // Timing of each instance, index 0..3 = u_d1, u_d0, u_d3, u_sm.
    localparam int HA [4] = '{640, 640, 640, 8};
    localparam int HF [4] = '{16, 16, 16, 2};
    localparam int HS [4] = '{96, 96, 96, 3};
    localparam int HB [4] = '{48, 48, 48, 3};
    localparam int VA [4] = '{480, 480, 480, 6};
    localparam int VF [4] = '{10, 10, 10, 1};
    localparam int VS [4] = '{2, 2, 2, 2};
    localparam int VB [4] = '{33, 33, 33, 1};
    localparam int SD [4] = '{1, 0, 3, 1};

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       blank;
        logic       hs;
        logic       vs;
        logic       ls;
        logic       fs;
        logic [7:0] fc;
    } exp_t;
    typedef exp_t [3:0] exp4_t;

    exp4_t sb_q [$];
    exp4_t mon_e, mon_a;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state.
    int         m_hc [4];
    int         m_vc [4];
    int         m_fc [4];
    logic [3:0] m_hh [4];
    logic [3:0] m_vh [4];

    // Statistics gathered by the monitor, checked against hand-computed numbers at the end.
    int   first_fall_x [3] = '{-1, -1, -1};
    logic prev_hs      [3] = '{1'b1, 1'b1, 1'b1};
    int   hs_low_l0    [3] = '{0, 0, 0};
    int   sm_fs_cnt    = 0;
    int   sm_fc_max    = 0;
    logic sm_wrap_seen = 1'b0;
    logic [7:0] prev_fc3 = 8'd0;
    logic win = 1'b0;

    function automatic string dut_name(input int i);
        case (i)
            0:       return "d1";
            1:       return "d0";
            2:       return "d3";
            default: return "small";
        endcase
    endfunction

    function automatic logic hs_raw(input int i, input int h);
        return !((h >= HA[i] + HF[i]) && (h < HA[i] + HF[i] + HS[i]));
    endfunction

    function automatic logic vs_raw(input int i, input int v);
        return !((v >= VA[i] + VF[i]) && (v < VA[i] + VF[i] + VS[i]));
    endfunction

    task automatic reset_models();
        for (int i = 0; i < 4; i++) begin
            m_hc[i] = 0;
            m_vc[i] = 0;
            m_fc[i] = 0;
            m_hh[i] = 4'hF;
            m_vh[i] = 4'hF;
        end
    endtask

    task automatic advance_models();
        for (int i = 0; i < 4; i++) begin
            int ht;
            int vt;
            ht = HA[i] + HF[i] + HS[i] + HB[i];
            vt = VA[i] + VF[i] + VS[i] + VB[i];
            m_hh[i] = {m_hh[i][2:0], hs_raw(i, m_hc[i])};
            m_vh[i] = {m_vh[i][2:0], vs_raw(i, m_vc[i])};
            if ((m_hc[i] == ht - 1) && (m_vc[i] == vt - 1)) m_fc[i] = (m_fc[i] + 1) % 256;
            if (m_hc[i] == ht - 1) begin
                m_hc[i] = 0;
                m_vc[i] = (m_vc[i] == vt - 1) ? 0 : m_vc[i] + 1;
            end else begin
                m_hc[i] = m_hc[i] + 1;
            end
        end
    endtask

    function automatic exp_t expect_of(input int i, input logic rst_now);
        exp_t e;
        e.x     = 10'(m_hc[i]);
        e.y     = 10'(m_vc[i]);
        e.blank = (m_hc[i] < HA[i]) && (m_vc[i] < VA[i]) && rst_now;
        e.hs    = (SD[i] == 0) ? hs_raw(i, m_hc[i]) : m_hh[i][SD[i] - 1];
        e.vs    = (SD[i] == 0) ? vs_raw(i, m_vc[i]) : m_vh[i][SD[i] - 1];
        e.ls    = (m_hc[i] == 0);
        e.fs    = (m_hc[i] == 0) && (m_vc[i] == 0);
        e.fc    = 8'(m_fc[i]);
        return e;
    endfunction

    // One clock of stimulus: advance the model on the edge, then drive reset and queue expectations.
    task automatic tick(input logic rst_val);
        exp4_t e;
        @(posedge clk);
        if (rst_n) advance_models();
        #1;
        rst_n = rst_val;
        if (!rst_n) reset_models();
        for (int i = 0; i < 4; i++) e[i] = expect_of(i, rst_n);
        sb_q.push_back(e);
    endtask

    task automatic check_int(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Scoreboard monitor: every negedge, compare all four instances with the queued expectation.
    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            mon_a[0] = '{if0.DrawX, if0.DrawY, if0.blank, if0.hs, if0.vs, if0.line_start, if0.frame_start, if0.frame_count};
            mon_a[1] = '{if1.DrawX, if1.DrawY, if1.blank, if1.hs, if1.vs, if1.line_start, if1.frame_start, if1.frame_count};
            mon_a[2] = '{if2.DrawX, if2.DrawY, if2.blank, if2.hs, if2.vs, if2.line_start, if2.frame_start, if2.frame_count};
            mon_a[3] = '{if3.DrawX, if3.DrawY, if3.blank, if3.hs, if3.vs, if3.line_start, if3.frame_start, if3.frame_count};
            for (int i = 0; i < 4; i++) begin
                n_vec++;
                if (mon_a[i] !== mon_e[i]) begin
                    n_bad++;
                    if (n_bad <= 20)
                        $display("FAIL raster_%s t=%0t got x=%0d y=%0d blank=%b hs=%b vs=%b ls=%b fs=%b fc=%0d expected x=%0d y=%0d blank=%b hs=%b vs=%b ls=%b fs=%b fc=%0d",
                                 dut_name(i), $time,
                                 mon_a[i].x, mon_a[i].y, mon_a[i].blank, mon_a[i].hs, mon_a[i].vs, mon_a[i].ls, mon_a[i].fs, mon_a[i].fc,
                                 mon_e[i].x, mon_e[i].y, mon_e[i].blank, mon_e[i].hs, mon_e[i].vs, mon_e[i].ls, mon_e[i].fs, mon_e[i].fc);
                end
            end
            for (int i = 0; i < 3; i++) begin
                if (prev_hs[i] && !mon_a[i].hs && (first_fall_x[i] < 0)) first_fall_x[i] = int'(mon_a[i].x);
                prev_hs[i] = mon_a[i].hs;
                if (!mon_a[i].hs && (mon_a[i].y == 10'd0)) hs_low_l0[i]++;
            end
            if (win && rst_n && if3.frame_start) sm_fs_cnt++;
            if (int'(if3.frame_count) > sm_fc_max) sm_fc_max = int'(if3.frame_count);
            if ((prev_fc3 == 8'd255) && (if3.frame_count == 8'd0)) sm_wrap_seen = 1'b1;
            prev_fc3 = if3.frame_count;
        end
    end

    initial begin
        rst_n = 1'b0;
        reset_models();

        // Reset held for 5 cycles.
        for (int k = 0; k < 5; k++) tick(1'b0);

        // Release; cycle 0 of the raster is (0,0).
        win = 1'b1;
        tick(1'b1);

        // Run until the small instance sits at (12,7) of its 257th frame, inside hs and vs pulses.
        for (int k = 0; k < 41084; k++) tick(1'b1);
        @(negedge clk);
        #1;
        win = 1'b0;

        // Mid-frame reset: outputs must clear before any further clock edge.
        tick(1'b0);
        #1;
        check_int("async_reset_x",  int'(if3.DrawX), 0);
        check_int("async_reset_y",  int'(if3.DrawY), 0);
        check_int("async_reset_hs", int'(if3.hs), 1);
        check_int("async_reset_vs", int'(if3.vs), 1);
        check_int("async_reset_big_x", int'(if0.DrawX), 0);
        tick(1'b0);
        tick(1'b0);
        tick(1'b1);
        for (int k = 0; k < 200; k++) tick(1'b1);

        @(negedge clk);
        #1;
        check_int("queue_drained", sb_q.size(), 0);

        // Hand-computed timing facts.
        check_int("hs_first_low_x_d1", first_fall_x[0], 657);
        check_int("hs_first_low_x_d0", first_fall_x[1], 656);
        check_int("hs_first_low_x_d3", first_fall_x[2], 659);
        check_int("hs_low_cycles_line0_d1", hs_low_l0[0], 96);
        check_int("hs_low_cycles_line0_d0", hs_low_l0[1], 96);
        check_int("hs_low_cycles_line0_d3", hs_low_l0[2], 96);
        check_int("small_frame_start_pulses", sm_fs_cnt, 257);
        check_int("small_frame_count_max", sm_fc_max, 255);
        check_int("small_frame_count_wrap", int'(sm_wrap_seen), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
